// File: rtl/arm_dual_mem_pkg.sv
// Shared widths, fault cause codes and elaboration helpers for the arm_dual_mem block.
package arm_dual_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BYTES  = WORD_W / BYTE_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTES-1:0]  be_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_UNMAPPED = 2'd2
  } fault_cause_e;

  // Index width for a word array; a single-word segment still needs one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arm_dual_mem_if.sv
// One memory access port: request side driven by the core, response side by the memory.
interface arm_dual_mem_if;
  import arm_dual_mem_pkg::*;

  logic  req;
  logic  we;
  word_t addr;
  be_t   be;
  word_t wdata;
  word_t rdata;
  logic  rvalid;
  logic  fault;

  modport master (output req, we, addr, be, wdata, input  rdata, rvalid, fault);
  modport slave  (input  req, we, addr, be, wdata, output rdata, rvalid, fault);

endinterface

// File: rtl/arm_dual_mem_decode.sv
// Combinational address decode for one port: alignment, segment hit and word offset.
module arm_dual_mem_decode
  import arm_dual_mem_pkg::*;
#(
  parameter word_t TEXT_START = 32'h0010_0000,
  parameter int    TEXT_WORDS = 256,
  parameter word_t DATA_START = 32'h0000_0000,
  parameter int    DATA_WORDS = 256,
  parameter int    OFF_W      = 8
) (
  input  word_t              addr_i,
  output logic               hit_text_o,
  output logic               hit_data_o,
  output logic               misalign_o,
  output logic [OFF_W-1:0]   word_off_o
);

  localparam word_t TEXT_BYTES = word_t'(TEXT_WORDS) << 2;
  localparam word_t DATA_BYTES = word_t'(DATA_WORDS) << 2;

  // An address below the base wraps to a huge difference, so one unsigned
  // compare covers both region bounds.
  always_comb begin
    misalign_o = (addr_i[1:0] != 2'b00);
    hit_text_o = !misalign_o && ((addr_i - TEXT_START) < TEXT_BYTES);
    hit_data_o = !misalign_o && !hit_text_o && ((addr_i - DATA_START) < DATA_BYTES);
    word_off_o = hit_data_o ? OFF_W'((addr_i - DATA_START) >> 2)
                            : OFF_W'((addr_i - TEXT_START) >> 2);
  end

endmodule

// File: rtl/arm_dual_mem.sv
// Dual-port byte-enabled text/data memory for the ARM core with per-port fault
// flags and a sticky first-fault capture register.
module arm_dual_mem
  import arm_dual_mem_pkg::*;
#(
  parameter word_t TEXT_START = 32'h0010_0000,
  parameter int    TEXT_WORDS = 256,
  parameter word_t DATA_START = 32'h0000_0000,
  parameter int    DATA_WORDS = 256,
  parameter int    BIG_ENDIAN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  arm_dual_mem_if.slave        p1_if,
  arm_dual_mem_if.slave        p2_if,
  input  logic                 excpt_clr_i,
  output logic                 excpt_o,
  output logic [1:0]           fault_cause_o,
  output word_t                fault_addr_o,
  output logic                 fault_port_o
);

  localparam int TW    = idx_w(TEXT_WORDS);
  localparam int DW    = idx_w(DATA_WORDS);
  localparam int OFF_W = (TW > DW) ? TW : DW;
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_START} + 33'(TEXT_WORDS) * 33'd4;
  localparam logic [32:0] DATA_END = {1'b0, DATA_START} + 33'(DATA_WORDS) * 33'd4;

  // Byte lane i always maps to bits [8i+7:8i]; endianness only decides which
  // byte address that lane represents, so storage is identical for both settings.
  if (TEXT_WORDS < 1 || DATA_WORDS < 1
      || TEXT_START[1:0] != 2'b00 || DATA_START[1:0] != 2'b00
      || TEXT_END[32] || DATA_END[32]
      || !((TEXT_END[31:0] <= DATA_START) || (DATA_END[31:0] <= TEXT_START))
      || (BIG_ENDIAN != 0 && BIG_ENDIAN != 1)) begin : g_bad_params
    $error("arm_dual_mem: illegal segment parameters");
  end

  // Index 0 is port 1, index 1 is port 2 throughout.
  logic [1:0]            req, we;
  logic [1:0][WORD_W-1:0] addr, wdata;
  logic [1:0][BYTES-1:0] be;
  logic [1:0]            hit_text, hit_data, misalign;
  logic [1:0][OFF_W-1:0] word_off;
  logic [1:0][TW-1:0]    tidx;
  logic [1:0][DW-1:0]    didx;
  logic [1:0]            flt, rd_ok, wr_text, wr_data;

  assign req   = {p2_if.req,   p1_if.req};
  assign we    = {p2_if.we,    p1_if.we};
  assign addr  = {p2_if.addr,  p1_if.addr};
  assign be    = {p2_if.be,    p1_if.be};
  assign wdata = {p2_if.wdata, p1_if.wdata};

  for (genvar p = 0; p < 2; p++) begin : g_port
    arm_dual_mem_decode #(
      .TEXT_START (TEXT_START),
      .TEXT_WORDS (TEXT_WORDS),
      .DATA_START (DATA_START),
      .DATA_WORDS (DATA_WORDS),
      .OFF_W      (OFF_W)
    ) u_decode (
      .addr_i     (addr[p]),
      .hit_text_o (hit_text[p]),
      .hit_data_o (hit_data[p]),
      .misalign_o (misalign[p]),
      .word_off_o (word_off[p])
    );
    assign tidx[p] = word_off[p][TW-1:0];
    assign didx[p] = word_off[p][DW-1:0];
  end

  assign flt     = req & ~(hit_text | hit_data);
  assign rd_ok   = req & ~we & ~flt;
  assign wr_text = {2{rst}} & req & we & hit_text;
  assign wr_data = {2{rst}} & req & we & hit_data;

  word_t text_mem [TEXT_WORDS];
  word_t data_mem [DATA_WORDS];

  // NOTE: memory arrays carry no reset so they map onto RAM macros; contents
  // survive rst and only the read/fault registers are cleared.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates resolve to the last one scheduled, so port 2
    // is written first and port 1 overrides it on lanes both ports enable.
    for (int p = 1; p >= 0; p--) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_text[p] && be[p][b]) text_mem[tidx[p]][b*BYTE_W +: BYTE_W] <= wdata[p][b*BYTE_W +: BYTE_W];
        if (wr_data[p] && be[p][b]) data_mem[didx[p]][b*BYTE_W +: BYTE_W] <= wdata[p][b*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [1:0][WORD_W-1:0] rdata_q;
  logic [1:0]             rvalid_q, fault_q;

  // Read data is sampled before this edge's writes land, giving read-first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      fault_q  <= '0;
    end else begin
      rvalid_q <= rd_ok;
      fault_q  <= flt;
      for (int p = 0; p < 2; p++) begin
        if (rd_ok[p]) rdata_q[p] <= hit_text[p] ? text_mem[tidx[p]] : data_mem[didx[p]];
      end
    end
  end

  logic         excpt_q, excpt_d;
  fault_cause_e cause_q, cause_d;
  word_t        faddr_q, faddr_d;
  logic         fport_q, fport_d;

  // Clear and capture in one cycle: the capture assignments come last and win.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    excpt_d = excpt_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    fport_d = fport_q;
    if (excpt_clr_i) begin
      excpt_d = 1'b0;
      cause_d = FC_NONE;
      faddr_d = '0;
      fport_d = 1'b0;
    end
    if (!excpt_q || excpt_clr_i) begin
      if (flt[0]) begin
        excpt_d = 1'b1;
        cause_d = misalign[0] ? FC_MISALIGN : FC_UNMAPPED;
        faddr_d = addr[0];
        fport_d = 1'b0;
      end else if (flt[1]) begin
        excpt_d = 1'b1;
        cause_d = misalign[1] ? FC_MISALIGN : FC_UNMAPPED;
        faddr_d = addr[1];
        fport_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      excpt_q <= 1'b0;
      cause_q <= FC_NONE;
      faddr_q <= '0;
      fport_q <= 1'b0;
    end else begin
      excpt_q <= excpt_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      fport_q <= fport_d;
    end
  end

  assign p1_if.rdata   = rdata_q[0];
  assign p2_if.rdata   = rdata_q[1];
  assign p1_if.rvalid  = rvalid_q[0];
  assign p2_if.rvalid  = rvalid_q[1];
  assign p1_if.fault   = fault_q[0];
  assign p2_if.fault   = fault_q[1];
  assign excpt_o       = excpt_q;
  assign fault_cause_o = cause_q;
  assign fault_addr_o  = faddr_q;
  assign fault_port_o  = fport_q;

endmodule

// File: tb/tb_arm_dual_mem.sv
// Randomized self-checking bench for arm_dual_mem against a byte-addressed
// reference model of the two segments and the first-fault register.
module tb_arm_dual_mem;

  localparam logic [31:0] TEXT_START = 32'h0010_0000;
  localparam int          TEXT_WORDS = 256;
  localparam logic [31:0] DATA_START = 32'h0000_0000;
  localparam int          DATA_WORDS = 256;
  localparam int          BIG_ENDIAN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        excpt_clr;
  logic        excpt;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        fault_port;

  arm_dual_mem_if p1_if ();
  arm_dual_mem_if p2_if ();

  always #5 clk = ~clk;

  arm_dual_mem #(
    .TEXT_START (TEXT_START),
    .TEXT_WORDS (TEXT_WORDS),
    .DATA_START (DATA_START),
    .DATA_WORDS (DATA_WORDS),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .p1_if         (p1_if),
    .p2_if         (p2_if),
    .excpt_clr_i   (excpt_clr),
    .excpt_o       (excpt),
    .fault_cause_o (fault_cause),
    .fault_addr_o  (fault_addr),
    .fault_port_o  (fault_port)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  // Shadow copies of the driven requests; the model only ever reads these.
  logic [1:0]  s_req, s_we;
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_be    [2];

  // Reference state: memory as individual bytes keyed by byte address.
  logic [7:0]  mb [logic [31:0]];
  logic [31:0] e_rdata [2];
  logic [1:0]  e_rvalid, e_fault;
  logic        e_excpt;
  logic [1:0]  e_cause;
  logic [31:0] e_faddr;
  logic        e_fport;

  task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    s_req[p] = req; s_we[p] = we; s_addr[p] = addr; s_be[p] = be; s_wdata[p] = wdata;
    if (p == 0) begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.be = be; p1_if.wdata = wdata;
    end else begin
      p2_if.req = req; p2_if.we = we; p2_if.addr = addr; p2_if.be = be; p2_if.wdata = wdata;
    end
  endtask

  task automatic idle();
    set_port(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    excpt_clr = 1'b0;
  endtask

  // Byte address held by lane l of the word at a.
  function automatic logic [31:0] lane_addr(input logic [31:0] a, input int l);
    return (BIG_ENDIAN != 0) ? a + 32'(3 - l) : a + 32'(l);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int l = 0; l < 4; l++) begin
      logic [31:0] ba = lane_addr(a, l);
      w[8*l +: 8] = mb.exists(ba) ? mb[ba] : 8'h00;
    end
    return w;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int l = 0; l < 4; l++) if (be[l]) mb[lane_addr(a, l)] = d[8*l +: 8];
  endtask

  // 0 = legal, 1 = misaligned, 2 = unmapped (same numbering as the cause codes).
  function automatic int classify(input logic [31:0] a);
    longint unsigned la   = {32'd0, a};
    longint unsigned t_lo = {32'd0, TEXT_START};
    longint unsigned d_lo = {32'd0, DATA_START};
    if (a[1:0] != 2'b00) return 1;
    if (la >= t_lo && la < t_lo + 4 * TEXT_WORDS) return 0;
    if (la >= d_lo && la < d_lo + 4 * DATA_WORDS) return 0;
    return 2;
  endfunction

  // Advance the model over one edge, clock the DUT, then compare all outputs.
  task automatic step();
    int   cls [2];
    logic old_excpt;
    bit   captured = 1'b0;
    if (!rst) begin
      e_rvalid = '0; e_fault = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      e_excpt = 1'b0; e_cause = 2'd0; e_faddr = '0; e_fport = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        cls[p]      = classify(s_addr[p]);
        e_fault[p]  = s_req[p] && (cls[p] != 0);
        e_rvalid[p] = s_req[p] && !s_we[p] && (cls[p] == 0);
        if (e_rvalid[p]) e_rdata[p] = mem_read(s_addr[p]);
      end
      old_excpt = e_excpt;
      if (excpt_clr) begin
        e_excpt = 1'b0; e_cause = 2'd0; e_faddr = '0; e_fport = 1'b0;
      end
      if (!old_excpt || excpt_clr) begin
        for (int p = 0; p < 2; p++) begin
          if (e_fault[p] && !captured) begin
            captured = 1'b1;
            e_excpt = 1'b1; e_cause = 2'(cls[p]); e_faddr = s_addr[p]; e_fport = 1'(p);
          end
        end
      end
      for (int p = 1; p >= 0; p--) begin
        if (s_req[p] && s_we[p] && cls[p] == 0) mem_write(s_addr[p], s_be[p], s_wdata[p]);
      end
    end
    @(posedge clk);
    #1;
    check("rvalid1", p1_if.rvalid, e_rvalid[0]);
    check("rvalid2", p2_if.rvalid, e_rvalid[1]);
    check("fault1",  p1_if.fault,  e_fault[0]);
    check("fault2",  p2_if.fault,  e_fault[1]);
    check("rdata1",  p1_if.rdata,  e_rdata[0]);
    check("rdata2",  p2_if.rdata,  e_rdata[1]);
    check("excpt",   excpt,        e_excpt);
    check("cause",   fault_cause,  e_cause);
    check("faddr",   fault_addr,   e_faddr);
    check("fport",   fault_port,   e_fport);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k   = $urandom_range(0, 9);
    logic [31:0] idx = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7))
                                                    : 32'($urandom_range(248, 255));
    case (k)
      0, 1, 2: return TEXT_START + 4 * idx;
      3, 4, 5: return DATA_START + 4 * idx;
      6:       return TEXT_START + 4 * idx + 32'($urandom_range(1, 3));
      7:       return TEXT_START + 32'(4 * TEXT_WORDS);
      8:       return ($urandom_range(0, 1) != 0) ? DATA_START - 32'd4 : DATA_START + 32'(4 * DATA_WORDS);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) step();
    rst = 1'b1;

    // Fill every word of both segments so any later read has a known value.
    for (int i = 0; i < 256; i++) begin
      set_port(0, 1'b1, 1'b1, TEXT_START + 32'(4 * i), 4'hF, $urandom());
      set_port(1, 1'b1, 1'b1, DATA_START + 32'(4 * i), 4'hF, $urandom());
      step();
    end
    idle();
    step();

    // Write on port 1, read back on port 2.
    set_port(0, 1'b1, 1'b1, 32'h0010_0000, 4'hF, 32'hDEAD_BEEF);
    step();
    idle();
    set_port(1, 1'b1, 1'b0, 32'h0010_0000, 4'h0, 32'h0);
    step();
    check("t1_rvalid2", p2_if.rvalid, 1'b1);
    check("t1_rdata2",  p2_if.rdata,  32'hDEAD_BEEF);

    // Partial byte-enable write.
    idle();
    set_port(0, 1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'h0);
    step();
    set_port(0, 1'b1, 1'b1, 32'h0000_0004, 4'b0101, 32'h1122_3344);
    step();
    set_port(0, 1'b1, 1'b0, 32'h0000_0004, 4'h0, 32'h0);
    step();
    check("t2_rdata1", p1_if.rdata, 32'h0022_0044);

    // Same-word writes from both ports; port 1 wins on shared lanes.
    set_port(0, 1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'h0000_00CC);
    step();
    set_port(0, 1'b1, 1'b1, 32'h0000_0008, 4'b1100, 32'hAAAA_AAAA);
    set_port(1, 1'b1, 1'b1, 32'h0000_0008, 4'b0110, 32'hBBBB_BBBB);
    step();
    idle();
    set_port(0, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0);
    step();
    check("t3_rdata1", p1_if.rdata, 32'hAAAA_BBCC);

    // Misaligned fault on port 2, then a later unmapped fault on port 1.
    idle();
    set_port(1, 1'b1, 1'b0, 32'h0000_0002, 4'h0, 32'h0);
    step();
    check("t4_fault2",  p2_if.fault,  1'b1);
    check("t4_rvalid2", p2_if.rvalid, 1'b0);
    check("t4_cause",   fault_cause,  2'd1);
    check("t4_faddr",   fault_addr,   32'h0000_0002);
    check("t4_fport",   fault_port,   1'b1);
    idle();
    set_port(0, 1'b1, 1'b0, 32'h0020_0000, 4'h0, 32'h0);
    step();
    check("t4_fault1",    p1_if.fault, 1'b1);
    check("t4_cause_hold", fault_cause, 2'd1);
    check("t4_faddr_hold", fault_addr,  32'h0000_0002);

    // Clear and new fault together: the new fault is captured.
    set_port(0, 1'b1, 1'b0, 32'h0500_0000, 4'h0, 32'h0);
    excpt_clr = 1'b1;
    step();
    check("t5_excpt", excpt,       1'b1);
    check("t5_cause", fault_cause, 2'd2);
    check("t5_faddr", fault_addr,  32'h0500_0000);
    idle();
    excpt_clr = 1'b1;
    step();
    check("t5_cleared", excpt, 1'b0);

    // Reset overrides a read in flight; memory keeps its contents.
    idle();
    set_port(0, 1'b1, 1'b0, 32'h0010_0000, 4'h0, 32'h0);
    rst = 1'b0;
    step();
    check("t6_rvalid1", p1_if.rvalid, 1'b0);
    idle();
    step();
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h0010_0000, 4'h0, 32'h0);
    step();
    check("t6_rdata1", p1_if.rdata, 32'hDEAD_BEEF);

    // Random traffic, with frequent same-address collisions, clears and resets.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a0 = rand_addr();
      logic [31:0] a1 = ($urandom_range(0, 1) != 0) ? a0 : rand_addr();
      set_port(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a0, 4'($urandom()), $urandom());
      set_port(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a1, 4'($urandom()), $urandom());
      excpt_clr = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
